// File: rtl/tt_pkg.sv
// Shared constants for the truth-table scanner: state encoding, vector count and index width.
package tt_pkg;

  localparam int N_VEC    = 16;
  localparam int IDX_W    = 4;
  localparam int SETTLE_W = 3;
  localparam int CNT_W    = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic [N_VEC-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    logic [N_VEC-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/truth_table_scan_if.sv
// Signal bundle between the scanner and its environment (function under test plus controller).
// The scanner owns the slave modport; whoever drives start/expected and returns s owns master.
interface truth_table_scan_if;
  import tt_pkg::*;

  logic                 start;
  logic [N_VEC-1:0]     expected;
  logic                 s;
  logic                 x;
  logic                 y;
  logic                 w;
  logic                 z;
  logic                 busy;
  logic                 done;
  logic [N_VEC-1:0]     mask;
  logic [CNT_W-1:0]     count;
  logic                 match;
  logic [1:0]           dbg_state;

  modport master (
    output start, expected, s,
    input  x, y, w, z, busy, done, mask, count, match, dbg_state
  );

  modport slave (
    input  start, expected, s,
    output x, y, w, z, busy, done, mask, count, match, dbg_state
  );

endinterface

// File: rtl/truth_table_scan.sv
// Walks all 16 input vectors of a 4-input combinational function, captures its truth table,
// counts the ones and compares the table against a reference mask latched at start.
module truth_table_scan
  import tt_pkg::*;
#(
  parameter int SETTLE = 0
) (
  input logic               clk,
  input logic               rst_n,
  truth_table_scan_if.slave bus
);

  localparam logic [SETTLE_W-1:0] SETTLE_L = SETTLE_W'(SETTLE);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_VEC - 1);

  logic [1:0]          state_q,  state_d;
  logic [IDX_W-1:0]    idx_q,    idx_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [N_VEC-1:0]    exp_q,    exp_d;
  logic [N_VEC-1:0]    mask_q,   mask_d;
  logic [CNT_W-1:0]    count_q,  count_d;
  logic                match_q,  match_d;

  logic             s_bit;
  logic             accept;
  logic             sample;
  logic [N_VEC-1:0] mask_smp;

  // An unknown s is recorded as 0 so a floating function output never counts as a one.
  assign s_bit    = (bus.s === 1'b1);
  assign accept   = bus.start && (state_q != ST_SCAN);
  assign sample   = (state_q == ST_SCAN) && (settle_q == SETTLE_L);
  assign mask_smp = mask_q | (s_bit ? idx_onehot(idx_q) : '0);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    exp_d    = exp_q;
    mask_d   = mask_q;
    count_d  = count_q;
    match_d  = match_q;

    case (state_q)
      ST_SCAN: begin
        if (sample) begin
          mask_d   = mask_smp;
          count_d  = count_q + {{(CNT_W-1){1'b0}}, s_bit};
          settle_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            idx_d   = '0;
            match_d = (mask_smp == exp_q);
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A start seen in IDLE or DONE overrides the default transition on the same edge.
    if (accept) begin
      state_d  = ST_SCAN;
      idx_d    = '0;
      settle_d = '0;
      exp_d    = bus.expected;
      mask_d   = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      settle_q <= '0;
      exp_q    <= '0;
      mask_q   <= '0;
      count_q  <= '0;
      match_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      exp_q    <= exp_d;
      mask_q   <= mask_d;
      count_q  <= count_d;
      match_q  <= match_d;
    end
  end

  assign bus.busy      = (state_q == ST_SCAN);
  assign bus.done      = (state_q == ST_DONE);
  assign {bus.x, bus.y, bus.w, bus.z} = bus.busy ? idx_q : '0;
  assign bus.mask      = mask_q;
  assign bus.count     = count_q;
  assign bus.match     = match_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_truth_table_scan.sv
// Bench for truth_table_scan: two instances (SETTLE=0 and SETTLE=2) each driven by a 4-input
// function beside it, checked against a truth-table model built by evaluating that function.
module tb_truth_table_scan;
  import tt_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  truth_table_scan_if if0();
  truth_table_scan_if if2();

  truth_table_scan #(.SETTLE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  truth_table_scan #(.SETTLE(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  // ---------------- function under test ----------------
  // mode 0: sum-of-products circuit, 1: tied high, 2: arbitrary table
  logic [1:0]  fn_mode [2];
  logic [15:0] rnd_tt  [2];

  function automatic logic fut(input logic [1:0] mode, input logic [15:0] tt, input logic [3:0] v);
    logic x, y, w, z;
    {x, y, w, z} = v;
    case (mode)
      2'd0:    return ~(~(~x & y & ~w) & ~(x & y & z) & ~(~y & w));
      2'd1:    return 1'b1;
      default: return tt[v];
    endcase
  endfunction

  always_comb begin
    if0.s = fut(fn_mode[0], rnd_tt[0], {if0.x, if0.y, if0.w, if0.z});
    if2.s = fut(fn_mode[1], rnd_tt[1], {if2.x, if2.y, if2.w, if2.z});
  end

  // Reference truth table: evaluate the function at every index 0..15.
  function automatic logic [15:0] ref_table(input logic [1:0] mode, input logic [15:0] tt);
    logic [15:0] t;
    for (int i = 0; i < 16; i++) t[i] = fut(mode, tt, 4'(i));
    return t;
  endfunction

  // ---------------- observation ----------------
  logic        busy_a [2];
  logic        done_a [2];
  logic        match_a[2];
  logic [3:0]  vec_a  [2];
  logic [15:0] mask_a [2];
  logic [4:0]  cnt_a  [2];
  logic [1:0]  st_a   [2];

  assign busy_a[0]  = if0.busy;   assign busy_a[1]  = if2.busy;
  assign done_a[0]  = if0.done;   assign done_a[1]  = if2.done;
  assign match_a[0] = if0.match;  assign match_a[1] = if2.match;
  assign vec_a[0]   = {if0.x, if0.y, if0.w, if0.z};
  assign vec_a[1]   = {if2.x, if2.y, if2.w, if2.z};
  assign mask_a[0]  = if0.mask;   assign mask_a[1]  = if2.mask;
  assign cnt_a[0]   = if0.count;  assign cnt_a[1]   = if2.count;
  assign st_a[0]    = if0.dbg_state; assign st_a[1] = if2.dbg_state;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [21:0] exp_q[$];
  logic [21:0] last_res[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic set_in(input int sel, input logic st, input logic [15:0] ex);
    if (sel == 0) begin
      if0.start = st; if0.expected = ex;
    end else begin
      if2.start = st; if2.expected = ex;
    end
  endtask

  task automatic set_start(input int sel, input logic st);
    if (sel == 0) if0.start = st;
    else          if2.start = st;
  endtask

  // One full scan. pre: start already raised by a chained previous scan.
  // ignore_at: scan cycle at which a stray start is pulsed (-1 for none).
  // chain: raise start with next_exp during the done cycle.
  task automatic do_scan(input int sel, input logic [15:0] exp_v, input int ignore_at,
                         input bit chain, input logic [15:0] next_exp, input bit pre);
    int          st;
    int          len;
    logic [15:0] tt;
    logic [21:0] res;
    st  = (sel == 0) ? 0 : 2;
    len = 16 * (st + 1);
    tt  = ref_table(fn_mode[sel], rnd_tt[sel]);
    if (!pre) begin
      @(negedge clk);
      set_in(sel, 1'b1, exp_v);
    end
    exp_q.push_back({(tt == exp_v), 5'($countones(tt)), tt});
    @(negedge clk);
    // Changing expected after the accepting edge must not influence match.
    set_in(sel, 1'b0, 16'($urandom));
    chk("scan_entry", {busy_a[sel], done_a[sel], vec_a[sel]}, {1'b1, 1'b0, 4'd0});
    chk("scan_clear", {cnt_a[sel], mask_a[sel]}, 21'd0);
    for (int c = 1; c < len; c++) begin
      @(negedge clk);
      set_start(sel, c == ignore_at);
      chk("scan_vec", {busy_a[sel], done_a[sel], vec_a[sel]}, {1'b1, 1'b0, 4'(c / (st + 1))});
    end
    @(negedge clk);
    set_start(sel, 1'b0);
    res = exp_q.pop_front();
    last_res[sel] = res;
    chk("done_pulse", {busy_a[sel], done_a[sel], vec_a[sel]}, {1'b0, 1'b1, 4'd0});
    chk("mask", mask_a[sel], res[15:0]);
    chk("count", cnt_a[sel], res[20:16]);
    chk("match", match_a[sel], res[21]);
    if (chain) set_in(sel, 1'b1, next_exp);
  endtask

  task automatic hold_check(input int sel);
    repeat (3) @(negedge clk);
    chk("idle_flags", {busy_a[sel], done_a[sel], vec_a[sel]}, 6'd0);
    chk("hold_result", {match_a[sel], cnt_a[sel], mask_a[sel]}, last_res[sel]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] tt;
    logic [15:0] ev;
    rst_n      = 1'b0;
    fn_mode[0] = 2'd0; fn_mode[1] = 2'd1;
    rnd_tt[0]  = '0;   rnd_tt[1]  = '0;
    set_in(0, 1'b0, '0);
    set_in(1, 1'b0, '0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++)
      chk("reset_state", {st_a[i], busy_a[i], done_a[i], vec_a[i], match_a[i], cnt_a[i], mask_a[i]}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // SoP circuit: the known table, matching and non-matching reference
    chk("sop_model", ref_table(2'd0, '0), 16'hAC3C);
    do_scan(0, 16'hAC3C, -1, 1'b0, '0, 1'b0);
    chk("sop_match_const", {match_a[0], cnt_a[0], mask_a[0]}, {1'b1, 5'd8, 16'hAC3C});
    hold_check(0);
    do_scan(0, 16'hAC3D, -1, 1'b0, '0, 1'b0);
    chk("sop_miss_const", {match_a[0], cnt_a[0], mask_a[0]}, {1'b0, 5'd8, 16'hAC3C});
    hold_check(0);

    // Stray start during the scan is ignored
    do_scan(0, 16'hAC3C, 5, 1'b0, '0, 1'b0);
    hold_check(0);

    // s tied high with settle window of 3 cycles
    do_scan(1, 16'hFFFF, -1, 1'b0, '0, 1'b0);
    chk("tied_const", {match_a[1], cnt_a[1], mask_a[1]}, {1'b1, 5'd16, 16'hFFFF});
    hold_check(1);
    do_scan(1, 16'h1234, 7, 1'b0, '0, 1'b0);
    hold_check(1);

    // Reset in the middle of a scan, at index 9
    @(negedge clk);
    set_in(0, 1'b1, 16'hAC3C);
    @(negedge clk);
    set_in(0, 1'b0, 16'hAC3C);
    repeat (9) @(negedge clk);
    chk("pre_reset_vec", vec_a[0], 4'd9);
    rst_n = 1'b0;
    #1;
    chk("async_reset", {st_a[0], busy_a[0], done_a[0], vec_a[0], match_a[0], cnt_a[0], mask_a[0]}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_resume", {busy_a[0], done_a[0], vec_a[0], cnt_a[0], mask_a[0]}, '0);
    do_scan(0, 16'hAC3C, -1, 1'b0, '0, 1'b0);

    // Restart during the done cycle, chained back-to-back
    fn_mode[0] = 2'd2;
    rnd_tt[0]  = 16'h0F0F;
    do_scan(0, 16'h0F0F, -1, 1'b1, 16'h5555, 1'b1 ^ 1'b1);
    rnd_tt[0]  = 16'h0F0F;
    do_scan(0, 16'h5555, -1, 1'b0, '0, 1'b1);
    hold_check(0);

    // Randomized tables on both instances
    fn_mode[0] = 2'd2; fn_mode[1] = 2'd2;
    for (int r = 0; r < 8; r++) begin
      int sel;
      sel         = r % 2;
      rnd_tt[sel] = 16'($urandom);
      tt          = ref_table(2'd2, rnd_tt[sel]);
      ev          = ($urandom_range(0, 1) == 1) ? tt : 16'($urandom);
      do_scan(sel, ev, (r < 4) ? int'($urandom_range(1, 10)) : -1, 1'b0, '0, 1'b0);
      hold_check(sel);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/truth_table_scan.md
TRUTH_TABLE_SCAN -- requirements
Module: truth_table_scan

Interface
REQ-001 SHALL have parameter SETTLE, default 0, meaning extra wait cycles per input vector before s is sampled (range 0..7).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a scan.
REQ-005 SHALL have port expected  input  16  reference minterm mask; bit i corresponds to vector index i.
REQ-006 SHALL have port s  input  1  output of the combinational function under test.
REQ-007 SHALL have ports x, y, w, z  output  1 each  registered drive of the function inputs; index i = {x,y,w,z}, x = MSB.
REQ-008 SHALL have port busy  output  1  high while a scan is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when a scan completes.
REQ-010 SHALL have port mask  output  16  captured truth table, bit i = s sampled at vector i.
REQ-011 SHALL have port count  output  5  number of 1 bits in mask (0..16).
REQ-012 SHALL have port match  output  1  high when mask equals the captured expected value.

Function
REQ-013 SHALL implement FSM states IDLE, SCAN, DONE; IDLE->SCAN on start, SCAN->DONE after the vector-15 sample, DONE->IDLE after one cycle unless start is high.
REQ-014 SHALL accept start only in IDLE or DONE; start in SCAN is ignored with no effect on index, mask or timing.
REQ-015 SHALL, on the edge accepting start, clear mask and count, set index to 0, capture expected into an internal register, and drive busy=1.
REQ-016 SHALL hold each index on {x,y,w,z} for SETTLE+1 cycles and sample s into mask[index] on the last edge of that window.
REQ-017 SHALL increment count on each sample with s=1; count SHALL reach 16 without wrapping.
REQ-018 SHALL advance the index by 1 after each sample; after index 15 is sampled it SHALL enter DONE, with no wrap to 0.
REQ-019 SHALL make a full scan take exactly 16*(SETTLE+1) cycles from the start edge to the DONE-entry edge; done is high in the following cycle.
REQ-020 SHALL register match on the DONE-entry edge as (final mask == captured expected); changes on expected after start SHALL NOT affect match.
REQ-021 SHALL drive x,y,w,z = 0 in IDLE and DONE, with busy=0 in both states.
REQ-022 SHALL hold mask, count and match stable from DONE until the next accepted start.
REQ-023 SHALL, on start during DONE, go directly to SCAN and apply REQ-015 on the same edge; done is still high that cycle.
REQ-024 SHALL treat s as 0 when it is unknown at a sample edge, in both mask and count.

Reset
REQ-025 SHALL, on rst_n low (any time, including mid-scan), immediately force state IDLE, index 0, settle counter 0, and captured expected 0.
REQ-026 SHALL, on rst_n low, force x=y=w=z=0, busy=0, done=0, mask=0, count=0, match=0.
REQ-027 SHALL, after rst_n deasserts, require a new start; no partial scan resumes.

Structure
REQ-028 SHALL place the state encoding (IDLE=0, SCAN=1, DONE=2, 2 bits), N_VEC=16 and the index width of 4 in shared package tt_pkg.
REQ-029 SHALL be a single module with no sub-module; the combinational function under test is instantiated beside it in the bench, not inside it.

Verification
REQ-030 SHALL cover: SETTLE=0, SoP s=~(~(~x&y&~w)&~(x&y&z)&~(~y&w)), expected=16'hAC3C, start at edge k -> done high after edge k+16, mask=16'hAC3C, count=8, match=1.
REQ-031 SHALL cover: same circuit, expected=16'hAC3D -> mask=16'hAC3C, count=8, match=0.
REQ-032 SHALL cover: s tied 1, SETTLE=2 -> done high after edge k+48, mask=16'hFFFF, count=16, match per expected.
REQ-033 SHALL cover: start pulsed again at cycle 5 of a scan -> ignored; done still at k+16 with identical results.
REQ-034 SHALL cover: rst_n low at index 9 -> all outputs 0 at once; a later start runs a full fresh 16-vector scan.
REQ-035 SHALL cover: start asserted during the done cycle -> immediate rescan, busy=1 next cycle, mask cleared.
